// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: constants shared by the ripple clock divider, tick counter and display logic
package clkdiv_pkg;
  localparam int DIV_BITS = 3;
  localparam logic [1:0] SEL_FREERUN = 2'd3;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MAX = 9;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: rising-edge detector on an already-synchronised bit, muted on source change
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic sel_chg,
  output logic rise
);
  logic prev;
  if (SYNC_STAGES < 2) begin : g_chk
    $error("SYNC_STAGES must be at least 2");
  end
  // prev always tracks d, so a source switch reloads it with the new bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= d;
  assign rise = d & ~prev & ~sel_chg;
endmodule

// File: rtl/divclk_tick_counter.sv
// divclk_tick_counter: synchronises a selected divided-clock bit into clk and
// counts its rising edges modulo MAX+1 with wrap pulse
module divclk_tick_counter
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX = DEF_MAX,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_BITS-1:0] divclock,
  input  logic [1:0]          sel,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic                tick,
  output logic [WIDTH-1:0]    count,
  output logic                tc
);
  logic [DIV_BITS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [DIV_BITS-1:0] synced;
  logic [1:0] sel_q;
  logic sel_chg, d, det, edge_c, tc_d;
  logic [WIDTH-1:0] max_v, load_c, count_d;
  if (MAX > 2 ** WIDTH - 1 || MAX < 1) begin : g_chk
    $error("MAX out of range for WIDTH");
  end
  // every bit gets its own chain; the mux only ever sees synchronised bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else for (int i = 0; i < DIV_BITS; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], divclock[i]};
  for (genvar i = 0; i < DIV_BITS; i++) begin : g_sync
    assign synced[i] = sync_q[i][SYNC_STAGES-1];
  end
  assign sel_chg = sel != sel_q;
  assign d = (sel == SEL_FREERUN) ? 1'b0 : synced[sel];
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .sel_chg(sel_chg),
    .rise   (det)
  );
  assign edge_c = ~sel_chg & ((sel == SEL_FREERUN) | det);
  assign max_v = WIDTH'(MAX);
  assign load_c = (load_val > max_v) ? max_v : load_val;
  always_comb begin
    count_d = count;
    tc_d = 1'b0;
    if (load) count_d = load_c;
    else if (en & edge_c) begin
      tc_d = up ? (count == max_v) : (count == '0);
      count_d = up ? (tc_d ? '0 : count + 1'b1) : (tc_d ? max_v : count - 1'b1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_q <= '0;
      tick <= 1'b0;
      count <= '0;
      tc <= 1'b0;
    end else begin
      sel_q <= sel;
      tick <= edge_c;
      count <= count_d;
      tc <= tc_d;
    end
endmodule

// File: tb/tb_divclk_tick_counter.sv
// tb_divclk_tick_counter: directed and random checks of the tick counter against a delay-line model
module tb_divclk_tick_counter;
  localparam int W = 4, MX = 9, S = 2;
  logic clk = 0, rst_n = 0;
  logic [2:0] divclock = '0;
  logic [1:0] sel = '0;
  logic en = 0, up = 1, load = 0;
  logic [W-1:0] load_val = '0;
  logic tick, tc;
  logic [W-1:0] count;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  divclk_tick_counter #(.WIDTH(W), .MAX(MX), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .divclock(divclock), .sel(sel), .en(en), .up(up),
    .load(load), .load_val(load_val), .tick(tick), .count(count), .tc(tc)
  );

  // model: the synchroniser is just an S-cycle delay of divclock samples
  logic [2:0] hist[$];
  logic [2:0] s_now, s_old;
  int m_count = 0, m_ld;
  bit m_tick = 0, m_tc = 0, m_e;
  logic [1:0] m_selq = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      repeat (S + 1) hist.push_back(3'b000);
      m_count = 0; m_tick = 0; m_tc = 0; m_selq = '0;
    end else begin
      hist.push_back(divclock);
      s_old = hist[0];
      s_now = hist[1];
      void'(hist.pop_front());
      if (sel != m_selq) m_e = 0;
      else if (sel == 2'd3) m_e = 1;
      else m_e = s_now[sel] & ~s_old[sel];
      m_tc = 0;
      m_ld = (int'(load_val) > MX) ? MX : int'(load_val);
      if (load) m_count = m_ld;
      else if (en && m_e) begin
        if (up) begin
          if (m_count == MX) begin m_count = 0; m_tc = 1; end else m_count++;
        end else begin
          if (m_count == 0) begin m_count = MX; m_tc = 1; end else m_count--;
        end
      end
      m_tick = m_e;
      m_selq = sel;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_count", 32'(count), 32'(m_count));
    check("model_tc", 32'(tc), 32'(m_tc));
  end

  task automatic rise_chk(int b, int ec, bit etc);
    divclock[b] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("tick_early", 32'(tick), 0);
    @(negedge clk);
    check("tick_latency", 32'(tick), 1);
    check("count_edge", 32'(count), 32'(ec));
    check("tc_edge", 32'(tc), 32'(etc));
    divclock[b] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (4) begin
      @(negedge clk);
      divclock = ~divclock;
    end
    check("rst_count", 32'(count), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_tc", 32'(tc), 0);
    divclock = '0;
    rst_n = 1;
    en = 1; up = 1; sel = 0;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 10; i++) rise_chk(0, i % 10, i == 10);
    up = 0; load = 1; load_val = 0;
    @(negedge clk);
    load = 0;
    check("load0", 32'(count), 0);
    rise_chk(0, 9, 1);
    up = 1;
    rise_chk(0, 0, 1);
    load_val = 14; load = 1;
    @(negedge clk);
    load = 0;
    check("clamp_load", 32'(count), 9);
    divclock[0] = 1;
    @(negedge clk);
    @(negedge clk);
    load = 1; load_val = 3;
    @(negedge clk);
    check("load_edge_tick", 32'(tick), 1);
    check("load_edge_count", 32'(count), 3);
    load = 0; divclock[0] = 0;
    repeat (3) @(negedge clk);
    divclock[1] = 1;
    repeat (4) @(negedge clk);
    sel = 1;
    repeat (4) @(negedge clk);
    check("switch_count", 32'(count), 3);
    check("switch_tick", 32'(tick), 0);
    divclock[1] = 0;
    repeat (3) @(negedge clk);
    rise_chk(1, 4, 0);
    en = 0;
    repeat (5) rise_chk(1, 4, 0);
    en = 1;
    load_val = 5; load = 1;
    @(negedge clk);
    load = 0;
    check("pre_reset_count", 32'(count), 5);
    #2 rst_n = 0;
    #1 check("async_reset_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1; sel = 3;
    @(negedge clk);
    check("freerun_start", 32'(count), 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("freerun_count", 32'(count), 32'(i % 10));
      check("freerun_tc", 32'(tc), 32'(i % 10 == 0));
      check("freerun_tick", 32'(tick), 1);
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) divclock = 3'($urandom);
      if ($urandom_range(49) == 0) sel = 2'($urandom);
      en = $urandom_range(7) != 0;
      if ($urandom_range(39) == 0) up = ~up;
      load = $urandom_range(59) == 0;
      load_val = W'($urandom);
      if ($urandom_range(499) == 0) begin
        #3 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
